// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings and E/M register layout for the execute stage
package pipeline_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [6:0]  OPC_JALR  = 7'b1100111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] instr;
    } em_reg_t;

    // Bubble contents shared by reset and flush.
    function automatic em_reg_t em_bubble(input logic [31:0] nop);
        em_reg_t r;
        r       = '0;
        r.instr = nop;
        return r;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit integer ALU
module alu
    import pipeline_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  alu_control,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'd0, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_execute_em.sv
// rtl/pipeline_execute_em.sv - execute stage with operand forwarding and E/M register
// Optional branch statistics counters: PIPELINE_EXEC_BRSTAT_EN
module pipeline_execute_em #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            en,
    input  logic            clr,
    input  logic [31:0]     InstrE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PC_plus4E,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic [4:0]      ALUControlE,
    input  logic [1:0]      ALUSrcAE,
    input  logic            ALUSrcBE,
    input  logic [XLEN-1:0] bef_SrcAE,
    input  logic [XLEN-1:0] bef_SrcBE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [6:0]      opcodeE,
    input  logic [2:0]      funct3E,
    input  logic [4:0]      Ra1E,
    input  logic [4:0]      Ra2E,
    input  logic [4:0]      RdE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            MemWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PC_plus4M,
    output logic [2:0]      funct3M,
    output logic [4:0]      RdM,
`ifdef PIPELINE_EXEC_BRSTAT_EN
    output logic [31:0]     br_cnt,
    output logic [31:0]     br_taken_cnt,
`endif
    output logic [31:0]     InstrM
);

    import pipeline_pkg::*;

    em_reg_t         em_q;
    em_reg_t         em_d;
    logic [XLEN-1:0] m_value;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            br_taken;

    // M-stage value as it will eventually be written back (PC+4 for jumps).
    assign m_value = (em_q.result_src == RES_PC4) ? em_q.pc_plus4 : em_q.alu_result;

    always_comb begin
        fwd_a = bef_SrcAE;
        if (em_q.reg_write && em_q.rd != 5'd0 && em_q.rd == Ra1E)
            fwd_a = m_value;
        else if (RegWriteW && RdW != 5'd0 && RdW == Ra1E)
            fwd_a = ResultW;
    end

    always_comb begin
        fwd_b = bef_SrcBE;
        if (em_q.reg_write && em_q.rd != 5'd0 && em_q.rd == Ra2E)
            fwd_b = m_value;
        else if (RegWriteW && RdW != 5'd0 && RdW == Ra2E)
            fwd_b = ResultW;
    end

    always_comb begin
        src_a = '0;
        case (ALUSrcAE)
            2'd0:    src_a = fwd_a;
            2'd1:    src_a = PCE;
            default: src_a = '0;
        endcase
    end

    assign src_b = ALUSrcBE ? ImmExtE : fwd_b;

    alu u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (ALUControlE),
        .result      (alu_result)
    );

    always_comb begin
        br_taken = 1'b0;
        case (funct3E)
            BR_EQ:   br_taken = (fwd_a == fwd_b);
            BR_NE:   br_taken = (fwd_a != fwd_b);
            BR_LT:   br_taken = ($signed(fwd_a) < $signed(fwd_b));
            BR_GE:   br_taken = ($signed(fwd_a) >= $signed(fwd_b));
            BR_LTU:  br_taken = (fwd_a < fwd_b);
            BR_GEU:  br_taken = (fwd_a >= fwd_b);
            default: br_taken = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & br_taken);
    assign PCTargetE = (opcodeE == OPC_JALR) ? ((fwd_a + ImmExtE) & ~32'd1) : (PCE + ImmExtE);

    always_comb begin
        em_d            = '0;
        em_d.reg_write  = RegWriteE;
        em_d.result_src = ResultSrcE;
        em_d.mem_write  = MemWriteE;
        em_d.alu_result = alu_result;
        em_d.write_data = fwd_b;
        em_d.pc_plus4   = PC_plus4E;
        em_d.funct3     = funct3E;
        em_d.rd         = RdE;
        em_d.instr      = InstrE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            em_q <= em_bubble(NOP_INSTR);
        else if (clr)
            em_q <= em_bubble(NOP_INSTR);
        else if (en)
            em_q <= em_d;
    end

    assign RegWriteM  = em_q.reg_write;
    assign ResultSrcM = em_q.result_src;
    assign MemWriteM  = em_q.mem_write;
    assign ALUResultM = em_q.alu_result;
    assign WriteDataM = em_q.write_data;
    assign PC_plus4M  = em_q.pc_plus4;
    assign funct3M    = em_q.funct3;
    assign RdM        = em_q.rd;
    assign InstrM     = em_q.instr;

`ifdef PIPELINE_EXEC_BRSTAT_EN
    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            br_cnt       <= '0;
            br_taken_cnt <= '0;
        end else if (en && !clr && BranchE) begin
            br_cnt <= br_cnt + 32'd1;
            if (br_taken)
                br_taken_cnt <= br_taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_execute_em.sv
// tb/tb_pipeline_execute_em.sv - self-checking bench for pipeline_execute_em
module tb_pipeline_execute_em;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en, clr;
    logic [31:0] InstrE, PCE, PC_plus4E;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE, JumpE, BranchE;
    logic [4:0]  ALUControlE;
    logic [1:0]  ALUSrcAE;
    logic        ALUSrcBE;
    logic [31:0] bef_SrcAE, bef_SrcBE, ImmExtE;
    logic [6:0]  opcodeE;
    logic [2:0]  funct3E;
    logic [4:0]  Ra1E, Ra2E, RdE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PC_plus4M;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] InstrM;

    pipeline_execute_em dut (
        .clk(clk), .n_rst(n_rst), .en(en), .clr(clr),
        .InstrE(InstrE), .PCE(PCE), .PC_plus4E(PC_plus4E),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .bef_SrcAE(bef_SrcAE), .bef_SrcBE(bef_SrcBE), .ImmExtE(ImmExtE),
        .opcodeE(opcodeE), .funct3E(funct3E),
        .Ra1E(Ra1E), .Ra2E(Ra2E), .RdE(RdE),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PC_plus4M(PC_plus4M),
        .funct3M(funct3M), .RdM(RdM), .InstrM(InstrM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, clr;
        logic [31:0] instr, pc, pc4;
        logic        regwrite;
        logic [1:0]  ressrc;
        logic        memwrite, jump, branch;
        logic [4:0]  aluctl;
        logic [1:0]  srca;
        logic        srcb;
        logic [31:0] a, b, imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  ra1, ra2, rd;
        logic        regwritew;
        logic [4:0]  rdw;
        logic [31:0] resultw;
    } in_t;

    typedef struct {
        logic        regwrite;
        logic [1:0]  ressrc;
        logic        memwrite;
        logic [31:0] alu, wdata, pc4;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] instr;
    } mstate_t;

    typedef struct {
        in_t         v;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
        logic [31:0] exp_alu;
    } tv_t;

    int      n_cmp = 0;
    int      n_err = 0;
    mstate_t m;
    tv_t     tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mstate_t m_reset();
        mstate_t r;
        r = '{regwrite: 1'b0, ressrc: 2'd0, memwrite: 1'b0, alu: 32'd0, wdata: 32'd0,
              pc4: 32'd0, f3: 3'd0, rd: 5'd0, instr: 32'h0000_0033};
        return r;
    endfunction

    function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        return a < b;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            0:  return a + b;
            1:  return a + (~b) + 1;
            2:  return a * (32'd1 << s);
            3:  return {31'd0, slt(a, b)};
            4:  return {31'd0, a < b};
            5:  return (a | b) & ~(a & b);
            6:  return a / (32'd1 << s);
            7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] rf, input in_t v, input mstate_t ms);
        if (ms.regwrite && ra != 0 && ms.rd == ra) return (ms.ressrc == 2) ? ms.pc4 : ms.alu;
        if (v.regwritew && v.rdw != 0 && v.rdw == ra) return v.resultw;
        return rf;
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return slt(a, b);
            3'b101: return !slt(a, b);
            3'b110: return a < b;
            3'b111: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic in_t base();
        in_t v;
        v = '{en: 1'b1, clr: 1'b0, instr: 32'h0000_0013, pc: 32'h100, pc4: 32'h104,
              regwrite: 1'b0, ressrc: 2'd0, memwrite: 1'b0, jump: 1'b0, branch: 1'b0,
              aluctl: 5'd0, srca: 2'd0, srcb: 1'b0, a: 32'd0, b: 32'd0, imm: 32'd0,
              opc: 7'b0110011, f3: 3'd0, ra1: 5'd0, ra2: 5'd0, rd: 5'd0,
              regwritew: 1'b0, rdw: 5'd0, resultw: 32'd0};
        return v;
    endfunction

    function automatic in_t rnd();
        in_t v;
        v           = base();
        v.en        = ($urandom_range(0, 7) != 0);
        v.clr       = ($urandom_range(0, 15) == 0);
        v.instr     = $urandom;
        v.pc        = $urandom;
        v.pc4       = v.pc + 4;
        v.regwrite  = $urandom_range(0, 1);
        v.ressrc    = 2'($urandom_range(0, 2));
        v.memwrite  = $urandom_range(0, 1);
        v.jump      = ($urandom_range(0, 3) == 0);
        v.branch    = $urandom_range(0, 1);
        v.aluctl    = 5'($urandom_range(0, 13));
        v.srca      = 2'($urandom_range(0, 3));
        v.srcb      = $urandom_range(0, 1);
        v.a         = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        v.b         = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
        v.imm       = $urandom;
        v.opc       = ($urandom_range(0, 1) != 0) ? 7'b1100111 : 7'b1100011;
        v.f3        = 3'($urandom_range(0, 7));
        v.ra1       = 5'($urandom_range(0, 3));
        v.ra2       = 5'($urandom_range(0, 3));
        v.rd        = 5'($urandom_range(0, 3));
        v.regwritew = $urandom_range(0, 1);
        v.rdw       = 5'($urandom_range(0, 3));
        v.resultw   = $urandom;
        return v;
    endfunction

    task automatic check_m(input string tag);
        chk({tag, ".RegWriteM"},  {31'd0, RegWriteM},  {31'd0, m.regwrite});
        chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, m.ressrc});
        chk({tag, ".MemWriteM"},  {31'd0, MemWriteM},  {31'd0, m.memwrite});
        chk({tag, ".ALUResultM"}, ALUResultM, m.alu);
        chk({tag, ".WriteDataM"}, WriteDataM, m.wdata);
        chk({tag, ".PC_plus4M"},  PC_plus4M,  m.pc4);
        chk({tag, ".funct3M"},    {29'd0, funct3M}, {29'd0, m.f3});
        chk({tag, ".RdM"},        {27'd0, RdM},     {27'd0, m.rd});
        chk({tag, ".InstrM"},     InstrM, m.instr);
    endtask

    // One E-stage cycle: drive at negedge, check combinational redirect, clock, check M outputs.
    task automatic apply(input string tag, input in_t v, output logic pcsrc_s, output logic [31:0] tgt_s);
        logic [31:0] fa, fb, oa, ob;
        mstate_t     nx;
        @(negedge clk);
        en = v.en; clr = v.clr; InstrE = v.instr; PCE = v.pc; PC_plus4E = v.pc4;
        RegWriteE = v.regwrite; ResultSrcE = v.ressrc; MemWriteE = v.memwrite;
        JumpE = v.jump; BranchE = v.branch; ALUControlE = v.aluctl;
        ALUSrcAE = v.srca; ALUSrcBE = v.srcb; bef_SrcAE = v.a; bef_SrcBE = v.b;
        ImmExtE = v.imm; opcodeE = v.opc; funct3E = v.f3;
        Ra1E = v.ra1; Ra2E = v.ra2; RdE = v.rd;
        RegWriteW = v.regwritew; RdW = v.rdw; ResultW = v.resultw;
        #1;
        fa = fwd(v.ra1, v.a, v, m);
        fb = fwd(v.ra2, v.b, v, m);
        pcsrc_s = PCSrcE;
        tgt_s   = PCTargetE;
        chk({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, v.jump | (v.branch & taken_ref(v.f3, fa, fb))});
        chk({tag, ".PCTargetE"}, PCTargetE, (v.opc == 7'b1100111) ? ((fa + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm));
        oa = (v.srca == 0) ? fa : (v.srca == 1) ? v.pc : 32'd0;
        ob = v.srcb ? v.imm : fb;
        if (v.clr) nx = m_reset();
        else if (!v.en) nx = m;
        else nx = '{regwrite: v.regwrite, ressrc: v.ressrc, memwrite: v.memwrite,
                    alu: alu_ref(v.aluctl, oa, ob), wdata: fb, pc4: v.pc4,
                    f3: v.f3, rd: v.rd, instr: v.instr};
        @(posedge clk);
        #1;
        m = nx;
        check_m(tag);
    endtask

    function automatic tv_t mk_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] srca, input logic srcb, input logic [31:0] imm,
                                   input logic [31:0] exp);
        tv_t t;
        t.v = base();
        t.v.aluctl = op; t.v.a = a; t.v.b = b; t.v.srca = srca; t.v.srcb = srcb; t.v.imm = imm;
        t.exp_pcsrc = 1'b0;
        t.exp_tgt   = 32'h100 + imm;
        t.exp_alu   = exp;
        return t;
    endfunction

    function automatic tv_t mk_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic exp_pcsrc);
        tv_t t;
        t.v = base();
        t.v.branch = 1'b1; t.v.opc = 7'b1100011; t.v.f3 = f3;
        t.v.a = a; t.v.b = b; t.v.ra1 = 5'd1; t.v.ra2 = 5'd2;
        t.v.pc = 32'h1000_0000; t.v.imm = 32'h20; t.v.aluctl = 5'd1;
        t.exp_pcsrc = exp_pcsrc;
        t.exp_tgt   = 32'h1000_0020;
        t.exp_alu   = a - b;
        return t;
    endfunction

    initial begin
        in_t         v;
        logic        ps;
        logic [31:0] tg;

        tab.push_back(mk_alu(5'd0,  32'd5,         32'd7,  2'd0, 1'b0, 32'd0, 32'd12));
        tab.push_back(mk_alu(5'd1,  32'd5,         32'd7,  2'd0, 1'b0, 32'd0, 32'hFFFF_FFFE));
        tab.push_back(mk_alu(5'd2,  32'd1,         32'd33, 2'd0, 1'b0, 32'd0, 32'd2));
        tab.push_back(mk_alu(5'd3,  32'hFFFF_FFFF, 32'd1,  2'd0, 1'b0, 32'd0, 32'd1));
        tab.push_back(mk_alu(5'd4,  32'hFFFF_FFFF, 32'd1,  2'd0, 1'b0, 32'd0, 32'd0));
        tab.push_back(mk_alu(5'd5,  32'hF0F0_00FF, 32'h0FF0_0F0F, 2'd0, 1'b0, 32'd0, 32'hFF00_0FF0));
        tab.push_back(mk_alu(5'd6,  32'h8000_0000, 32'd4,  2'd0, 1'b0, 32'd0, 32'h0800_0000));
        tab.push_back(mk_alu(5'd7,  32'h8000_0000, 32'd4,  2'd0, 1'b0, 32'd0, 32'hF800_0000));
        tab.push_back(mk_alu(5'd8,  32'h0000_F000, 32'h0000_000F, 2'd0, 1'b0, 32'd0, 32'h0000_F00F));
        tab.push_back(mk_alu(5'd9,  32'h0000_FF00, 32'h0000_0FF0, 2'd0, 1'b0, 32'd0, 32'h0000_0F00));
        tab.push_back(mk_alu(5'd10, 32'd9,         32'd9,  2'd0, 1'b1, 32'hABCD_E000, 32'hABCD_E000));
        tab.push_back(mk_alu(5'd11, 32'd9,         32'd9,  2'd0, 1'b0, 32'd0, 32'd0));
        tab.push_back(mk_alu(5'd0,  32'd9,         32'd9,  2'd1, 1'b1, 32'h10, 32'h110));
        tab.push_back(mk_alu(5'd0,  32'd9,         32'd9,  2'd3, 1'b1, 32'h44, 32'h44));
        tab.push_back(mk_br(3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1));
        tab.push_back(mk_br(3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0));
        tab.push_back(mk_br(3'b000, 32'h1234,      32'h1234, 1'b1));
        tab.push_back(mk_br(3'b010, 32'd1,         32'd2, 1'b0));

        n_rst = 1'b0;
        v = base();
        en = 1; clr = 0; InstrE = 0; PCE = 0; PC_plus4E = 0; RegWriteE = 0; ResultSrcE = 0;
        MemWriteE = 0; JumpE = 0; BranchE = 0; ALUControlE = 0; ALUSrcAE = 0; ALUSrcBE = 0;
        bef_SrcAE = 0; bef_SrcBE = 0; ImmExtE = 0; opcodeE = 0; funct3E = 0;
        Ra1E = 0; Ra2E = 0; RdE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
        m = m_reset();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        #1;
        check_m("reset");

        for (int i = 0; i < tab.size(); i++) begin
            apply($sformatf("tab%0d", i), tab[i].v, ps, tg);
            chk($sformatf("tab%0d.pcsrc", i), {31'd0, ps}, {31'd0, tab[i].exp_pcsrc});
            chk($sformatf("tab%0d.tgt", i), tg, tab[i].exp_tgt);
            chk($sformatf("tab%0d.alu", i), ALUResultM, tab[i].exp_alu);
        end

        // ADD with M forward, then again with a competing W match.
        for (int k = 0; k < 2; k++) begin
            v = base(); v.rd = 5'd5; v.regwrite = 1; v.srca = 2'd2; v.srcb = 1; v.imm = 32'd7;
            apply("fwd_setup", v, ps, tg);
            v = base(); v.ra1 = 5'd5; v.a = 32'd1000; v.srcb = 1; v.imm = 32'd3; v.rd = 5'd6;
            if (k == 1) begin v.regwritew = 1; v.rdw = 5'd5; v.resultw = 32'd99; end
            apply("fwd_add", v, ps, tg);
            chk($sformatf("fwd_add%0d", k), ALUResultM, 32'd10);
        end

        // JALR redirect, then a dependent consumer picks up PC_plus4M.
        v = base(); v.jump = 1; v.opc = 7'b1100111; v.ra1 = 5'd3; v.a = 32'h1003; v.imm = 32'd4;
        v.ressrc = 2'd2; v.regwrite = 1; v.rd = 5'd7; v.pc4 = 32'h2004;
        apply("jalr", v, ps, tg);
        chk("jalr.pcsrc", {31'd0, ps}, 32'd1);
        chk("jalr.tgt", tg, 32'h1006);
        v = base(); v.ra1 = 5'd7; v.a = 32'h5555; v.srcb = 1; v.imm = 32'd0;
        apply("jalr_dep", v, ps, tg);
        chk("jalr_dep.alu", ALUResultM, 32'h2004);

        // Stall for three cycles with changing inputs.
        for (int k = 0; k < 3; k++) begin
            v = rnd(); v.en = 0; v.clr = 0;
            apply("stall", v, ps, tg);
            chk("stall.alu", ALUResultM, 32'h2004);
        end

        v = base(); v.clr = 1; v.regwrite = 1; v.memwrite = 1; v.instr = 32'hDEAD_BEEF;
        apply("flush", v, ps, tg);
        chk("flush.regwrite", {31'd0, RegWriteM}, 32'd0);
        chk("flush.memwrite", {31'd0, MemWriteM}, 32'd0);
        chk("flush.instr", InstrM, 32'h0000_0033);

        // x0 is never forwarded even when M claims to write it.
        v = base(); v.rd = 5'd0; v.regwrite = 1; v.srca = 2'd2; v.srcb = 1; v.imm = 32'h55;
        apply("x0_setup", v, ps, tg);
        v = base(); v.ra1 = 5'd0; v.a = 32'd0; v.srcb = 1; v.imm = 32'd0;
        apply("x0", v, ps, tg);
        chk("x0.alu", ALUResultM, 32'd0);

        for (int k = 0; k < 300; k++) begin
            v = rnd();
            apply("rand", v, ps, tg);
        end

        // Asynchronous reset mid-run, observed before any clock edge.
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        m = m_reset();
        chk("async_rst.instr", InstrM, 32'h0000_0033);
        check_m("async_rst");
        @(negedge clk);
        n_rst = 1'b1;

        for (int k = 0; k < 50; k++) begin
            v = rnd();
            apply("rand2", v, ps, tg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
